// File: rtl/des_dec_round_engine_pkg.sv
// Shared constants, tables and helpers for the iterative DES decrypt engine.
// Table entries use the classic DES numbering: position n is the n-th bit
// counted from the MSB end of the vector, which is how the encrypt stage and
// the published test vectors write their hex values.
package des_dec_round_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DES_ROUNDS = 16;

    // Left-shift schedule of the encrypt key path, indexed by encrypt round - 1.
    localparam int SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box is stored row-major: entry index = row*16 + column.
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [47:0] des_pc2(input logic [55:0] cd);
        logic [47:0] k;
        k = '0;
        for (int i = 0; i < 48; i++) begin
            k[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
        end
        return k;
    endfunction

    function automatic logic [47:0] des_expand(input logic [31:0] r);
        logic [47:0] e;
        e = '0;
        for (int i = 0; i < 48; i++) begin
            e[6'(47 - i)] = r[5'(32 - E_TBL[i])];
        end
        return e;
    endfunction

    // Row comes from the outer bits of each 6-bit group, column from the inner four.
    function automatic logic [31:0] des_sbox(input logic [47:0] x);
        logic [31:0] s_out;
        logic [5:0]  six;
        s_out = '0;
        for (int s = 0; s < 8; s++) begin
            six = x[6'(47 - 6 * s) -: 6];
            s_out[5'(31 - 4 * s) -: 4] = 4'(SBOX[3'(s)][{six[5], six[0], six[4:1]}]);
        end
        return s_out;
    endfunction

    function automatic logic [31:0] des_perm_p(input logic [31:0] s_in);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            p[5'(31 - i)] = s_in[5'(32 - P_TBL[i])];
        end
        return p;
    endfunction

    // Right rotation undoes the encrypt-side left shift (28-bit wrap).
    function automatic logic [27:0] des_rotr28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] y;
        if (n == 2'd2) begin
            y = {x[1:0], x[27:2]};
        end else begin
            y = {x[0], x[27:1]};
        end
        return y;
    endfunction

    // Rotation applied after decrypt round rnd mirrors encrypt round 17-rnd;
    // after round 16 it is encrypt round 1's shift, closing the 28-bit loop.
    function automatic logic [1:0] des_dec_shift(input logic [4:0] rnd);
        logic [3:0] idx;
        idx = 4'(5'd16 - rnd);
        return 2'(SHIFT_SCHED[idx]);
    endfunction

endpackage

// File: rtl/des_dec_round_engine_f_function.sv
// DES round function f(R, K) = P(S(E(R) xor K)); purely combinational.
module des_dec_round_engine_f_function
    import des_dec_round_engine_pkg::*;
(
    input  logic [31:0] i_r,
    input  logic [47:0] i_k,
    output logic [31:0] o_f
);

    logic [47:0] w_x;
    logic [31:0] w_s;

    assign w_x = des_expand(i_r) ^ i_k;
    assign w_s = des_sbox(w_x);
    assign o_f = des_perm_p(w_s);

endmodule

// File: rtl/des_dec_round_engine.sv
// Iterative DES decrypt core: one Feistel round per clock, subkeys K16..K1
// produced on the fly by right-rotating C/D. Results are the raw round-16
// halves so the shared swap + final-permutation stage can follow unchanged.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a block; data17 outputs hold the last result
//   ST_BUSY | running rounds 1..16, r_rnd = round being computed
//   ST_DONE | result presented with o_out_valid until o_out_ready
module des_dec_round_engine
    import des_dec_round_engine_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_data_l,
    input  logic [31:0] i_data_r,
    input  logic [55:0] i_key,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_data17_l,
    output logic [31:0] o_data17_r
);

    state_t      r_state;
    logic [4:0]  r_rnd;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [31:0] r_data17_l;
    logic [31:0] r_data17_r;
    logic        r_in_ready;
    logic        r_out_valid;

    logic [47:0] w_k;
    logic [31:0] w_f;
    logic [31:0] w_new_r;
    logic [1:0]  w_shift;

    // Round 1 sees the unrotated C/D, which equals C16/D16 and yields K16.
    assign w_k     = des_pc2({r_c, r_d});
    assign w_new_r = r_l ^ w_f;
    assign w_shift = des_dec_shift(r_rnd);

    des_dec_round_engine_f_function u_f (
        .i_r (r_r),
        .i_k (w_k),
        .o_f (w_f)
    );

    // Control FSM plus round datapath; all outputs registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_rnd       <= 5'd0;
            r_l         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_data17_l  <= '0;
            r_data17_r  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_l        <= i_data_l;
                        r_r        <= i_data_r;
                        r_c        <= i_key[55:28];
                        r_d        <= i_key[27:0];
                        r_rnd      <= 5'd1;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_l <= r_r;
                    r_r <= w_new_r;
                    r_c <= des_rotr28(r_c, w_shift);
                    r_d <= des_rotr28(r_d, w_shift);
                    if (r_rnd == 5'(DES_ROUNDS)) begin
                        r_data17_l  <= r_r;
                        r_data17_r  <= w_new_r;
                        r_out_valid <= 1'b1;
                        r_rnd       <= 5'd0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_rnd <= r_rnd + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rnd       <= 5'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_data17_l  = r_data17_l;
    assign o_data17_r  = r_data17_r;

endmodule

// File: tb/tb_des_dec_round_engine.sv
// Bench for the DES decrypt engine: a textbook DES encryptor model builds the
// ciphertext, the engine must hand back the original halves (swapped).
module tb_des_dec_round_engine;
    import des_dec_round_engine_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_data_l;
    logic [31:0] i_data_r;
    logic [55:0] i_key;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_data17_l;
    logic [31:0] o_data17_r;

    int checks = 0;
    int errors = 0;

    des_dec_round_engine dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_data_l    (i_data_l),
        .i_data_r    (i_data_r),
        .i_key       (i_key),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_data17_l  (o_data17_l),
        .o_data17_r  (o_data17_r)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- reference model (plain DES encryption) ----------------
    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        int          row, col;
        e = '0; s = '0; p = '0;
        for (int i = 1; i <= 48; i++) e[6'(48 - i)] = r[5'(32 - E_TBL[i - 1])];
        e = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six = e[6'(47 - 6 * b) -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s[5'(31 - 4 * b) -: 4] = 4'(SBOX[b][row * 16 + col]);
        end
        for (int i = 1; i <= 32; i++) p[5'(32 - i)] = s[5'(32 - P_TBL[i - 1])];
        return p;
    endfunction

    function automatic void ref_encrypt(input logic [31:0] l0, input logic [31:0] r0,
                                        input logic [55:0] key,
                                        output logic [31:0] l16, output logic [31:0] r16);
        int          sched [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        logic [47:0] ks [16];
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [31:0] l, r, t;
        c = key[55:28];
        d = key[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < sched[i]; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            ks[i] = '0;
            for (int b = 1; b <= 48; b++) ks[i][6'(48 - b)] = cd[6'(56 - PC2_TBL[b - 1])];
        end
        l = l0;
        r = r0;
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ ref_f(r, ks[i]);
            l = t;
        end
        l16 = l;
        r16 = r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Presents one block from IDLE and waits (bounded) for the result; leaves the DUT in DONE.
    task automatic run_block(input logic [31:0] l, input logic [31:0] r, input logic [55:0] k,
                             output logic [31:0] ol, output logic [31:0] orr, output int lat);
        i_data_l    = l;
        i_data_r    = r;
        i_key       = k;
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        step();
        i_in_valid = 1'b0;
        lat = 0;
        while (!o_out_valid && lat < 40) begin
            step();
            lat++;
        end
        checks++;
        if (o_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout got %b after %0d cycles want 1", o_out_valid, lat);
        end
        ol  = o_data17_l;
        orr = o_data17_r;
    endtask

    task automatic release_out();
        i_out_ready = 1'b1;
        step();
        i_out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", o_in_ready); end
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", o_out_valid); end
        checks++; if (o_data17_l !== 32'h0) begin errors++; $display("FAIL reset_data17_l got %h want 0", o_data17_l); end
        checks++; if (o_data17_r !== 32'h0) begin errors++; $display("FAIL reset_data17_r got %h want 0", o_data17_r); end
    endtask

    task automatic test_known_vector();
        logic [31:0] ol, orr;
        int lat;
        run_block(32'h0A4CD995, 32'h43423234, {28'hF0CCAAF, 28'h556678F}, ol, orr, lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL kv_latency got %0d want 16", lat); end
        checks++; if (ol !== 32'hF0AAF0AA) begin errors++; $display("FAIL kv_data17_l got %h want F0AAF0AA", ol); end
        checks++; if (orr !== 32'hCC00CCFF) begin errors++; $display("FAIL kv_data17_r got %h want CC00CCFF", orr); end
        checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL kv_in_ready_done got %b want 0", o_in_ready); end
    endtask

    // Runs right after the known vector while the DUT still sits in DONE.
    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            i_data_l   = $urandom();
            i_data_r   = $urandom();
            i_key      = {24'($urandom()), $urandom()};
            i_in_valid = 1'b1;
            step();
            checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b want 1", i, o_out_valid); end
            checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, o_in_ready); end
            checks++;
            if (o_data17_l !== 32'hF0AAF0AA || o_data17_r !== 32'hCC00CCFF) begin
                errors++;
                $display("FAIL bp_data_stable cyc %0d got %h_%h want F0AAF0AA_CC00CCFF", i, o_data17_l, o_data17_r);
            end
        end
        i_out_ready = 1'b1;
        step();
        i_out_ready = 1'b0;
        i_in_valid  = 1'b0;
        checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", o_out_valid); end
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", o_in_ready); end
        step();
        step();
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_not_queued got %b want 1", o_in_ready); end
        checks++;
        if (o_data17_l !== 32'hF0AAF0AA || o_data17_r !== 32'hCC00CCFF) begin
            errors++;
            $display("FAIL bp_idle_hold got %h_%h want F0AAF0AA_CC00CCFF", o_data17_l, o_data17_r);
        end
    endtask

    task automatic test_round_trip();
        logic [31:0] l0, r0, l16, r16, ol, orr;
        logic [55:0] k;
        int lat;
        for (int n = 0; n < 200; n++) begin
            l0 = $urandom();
            r0 = $urandom();
            k  = {24'($urandom()), $urandom()};
            ref_encrypt(l0, r0, k, l16, r16);
            run_block(r16, l16, k, ol, orr, lat);
            checks++; if (ol !== r0) begin errors++; $display("FAIL rt_data17_l blk %0d got %h want %h", n, ol, r0); end
            checks++; if (orr !== l0) begin errors++; $display("FAIL rt_data17_r blk %0d got %h want %h", n, orr, l0); end
            release_out();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] l0, r0, l16, r16, ol, orr;
        logic [55:0] k;
        logic seen;
        int lat;
        i_data_l   = $urandom();
        i_data_r   = $urandom();
        i_key      = {24'($urandom()), $urandom()};
        i_in_valid = 1'b1;
        step();
        i_in_valid = 1'b0;
        repeat (6) step();
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b want 1", o_in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (o_out_valid !== 1'b0) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid_rose got %b want 0", seen); end
        l0 = $urandom();
        r0 = $urandom();
        k  = {24'($urandom()), $urandom()};
        ref_encrypt(l0, r0, k, l16, r16);
        run_block(r16, l16, k, ol, orr, lat);
        checks++; if (ol !== r0 || orr !== l0) begin errors++; $display("FAIL mid_rst_next_block got %h_%h want %h_%h", ol, orr, r0, l0); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [31:0] fl [3];
        logic [31:0] fr [3];
        logic [55:0] fk [3];
        logic [31:0] el [3];
        logic [31:0] er [3];
        logic [31:0] l0, r0, l16, r16;
        int sent, got, last;
        for (int b = 0; b < 3; b++) begin
            l0 = $urandom();
            r0 = $urandom();
            fk[b] = {24'($urandom()), $urandom()};
            ref_encrypt(l0, r0, fk[b], l16, r16);
            fl[b] = r16; fr[b] = l16;
            el[b] = r0;  er[b] = l0;
        end
        sent = 0; got = 0; last = 0;
        i_out_ready = 1'b1;
        for (int t = 0; t < 120 && got < 3; t++) begin
            if (o_in_ready && sent < 3) begin
                i_data_l   = fl[sent];
                i_data_r   = fr[sent];
                i_key      = fk[sent];
                i_in_valid = 1'b1;
                sent++;
            end else begin
                i_in_valid = 1'b0;
            end
            step();
            if (o_out_valid) begin
                checks++;
                if (o_data17_l !== el[got] || o_data17_r !== er[got]) begin
                    errors++;
                    $display("FAIL b2b_data blk %0d got %h_%h want %h_%h", got, o_data17_l, o_data17_r, el[got], er[got]);
                end
                if (got > 0) begin
                    checks++;
                    if (t - last != 18) begin errors++; $display("FAIL b2b_spacing blk %0d got %0d want 18", got, t - last); end
                end
                last = t;
                got++;
            end
        end
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        checks++; if (got != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got); end
        step();
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        i_data_l    = '0;
        i_data_r    = '0;
        i_key       = '0;
        test_reset();
        test_known_vector();
        test_backpressure();
        test_round_trip();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
